// File: rtl/obi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// obi_rr_arbiter
//   Two-master / one-slave arbiter for the core-side req/gnt/rvalid memory bus.
//   Lets two cores share one single-port RAM. Grants are round-robin; responses
//   are routed in order using a small FIFO of outstanding transaction IDs.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   m{0,1}_req_i/gnt_o        master request / grant
//   m{0,1}_addr/we/be/wdata_i master request fields
//   m{0,1}_rvalid/rdata/err_o master response
//   s_req_o/s_gnt_i           slave request / grant
//   s_addr/we/be/wdata_o      slave request fields (muxed from selected master)
//   s_rvalid/rdata/err_i      slave response
//   proto_err_o               sticky: response seen with nothing outstanding
// -----------------------------------------------------------------------------
module obi_rr_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            m0_req_i,
    output logic            m0_gnt_o,
    output logic            m0_rvalid_o,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_be_i,
    input  logic [DW-1:0]   m0_wdata_i,
    output logic [DW-1:0]   m0_rdata_o,
    output logic            m0_err_o,
    input  logic            m1_req_i,
    output logic            m1_gnt_o,
    output logic            m1_rvalid_o,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_be_i,
    input  logic [DW-1:0]   m1_wdata_i,
    output logic [DW-1:0]   m1_rdata_o,
    output logic            m1_err_o,
    output logic            s_req_o,
    input  logic            s_gnt_i,
    input  logic            s_rvalid_i,
    output logic [AW-1:0]   s_addr_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_be_o,
    output logic [DW-1:0]   s_wdata_o,
    input  logic [DW-1:0]   s_rdata_i,
    input  logic            s_err_i,
    output logic            proto_err_o
);

    localparam int BW = DW / 8;
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);

    // Pointer increment that wraps modulo MAX_OUTST (depth need not be 2^n).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTST - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    logic           fifo_q [MAX_OUTST];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           prio_q, prio_d;
    logic           lock_q, lock_d;
    logic           lock_id_q, lock_id_d;
    logic           proto_err_q, proto_err_d;

    logic           sel_s;
    logic           sel_req_s;
    logic           s_req_s;
    logic           grant_s;
    logic           pop_s;
    logic           head_s;

    // Master selection: a locked master keeps the slave until it is granted.
    always_comb begin
        sel_s = 1'b0;
        if (lock_q) begin
            sel_s = lock_id_q;
        end else if (m0_req_i && m1_req_i) begin
            sel_s = prio_q;
        end else if (m1_req_i) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Request qualification; the full check ignores a same-cycle pop on purpose.
    always_comb begin
        sel_req_s = sel_s ? m1_req_i : m0_req_i;
        s_req_s   = sel_req_s && (count_q < CW'(MAX_OUTST)) && !rst_i;
        grant_s   = s_req_s && s_gnt_i;
        pop_s     = s_rvalid_i && (count_q != {CW{1'b0}}) && !rst_i;
        head_s    = fifo_q[rd_ptr_q];
    end

    // Slave-side request fields and master grants.
    always_comb begin
        s_req_o   = s_req_s;
        s_addr_o  = {AW{1'b0}};
        s_we_o    = 1'b0;
        s_be_o    = {BW{1'b0}};
        s_wdata_o = {DW{1'b0}};
        if (s_req_s) begin
            s_addr_o  = sel_s ? m1_addr_i  : m0_addr_i;
            s_we_o    = sel_s ? m1_we_i    : m0_we_i;
            s_be_o    = sel_s ? m1_be_i    : m0_be_i;
            s_wdata_o = sel_s ? m1_wdata_i : m0_wdata_i;
        end else begin
            s_addr_o  = {AW{1'b0}};
        end
        m0_gnt_o = grant_s && !sel_s;
        m1_gnt_o = grant_s && sel_s;
    end

    // Response routing to the master at the FIFO head, zero cycles latency.
    always_comb begin
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = {DW{1'b0}};
        m1_rdata_o  = {DW{1'b0}};
        m0_err_o    = 1'b0;
        m1_err_o    = 1'b0;
        if (pop_s) begin
            if (head_s) begin
                m1_rvalid_o = 1'b1;
                m1_rdata_o  = s_rdata_i;
                m1_err_o    = s_err_i;
            end else begin
                m0_rvalid_o = 1'b1;
                m0_rdata_o  = s_rdata_i;
                m0_err_o    = s_err_i;
            end
        end else begin
            m0_rvalid_o = 1'b0;
        end
        proto_err_o = proto_err_q;
    end

    // Next-state for FIFO pointers, occupancy, priority, lock and error flag.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        prio_d      = prio_q;
        lock_d      = lock_q;
        lock_id_d   = lock_id_q;
        proto_err_d = proto_err_q;

        if (grant_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            prio_d   = !sel_s;
            lock_d   = 1'b0;
        end else if (s_req_s) begin
            lock_d    = 1'b1;
            lock_id_d = sel_s;
        end else begin
            lock_d = lock_q;
        end

        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({grant_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (s_rvalid_i && (count_q == {CW{1'b0}})) begin
            proto_err_d = 1'b1;
        end else begin
            proto_err_d = proto_err_q;
        end
    end

    // State registers; reset discards every outstanding transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                fifo_q[i] <= 1'b0;
            end
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            prio_q      <= 1'b0;
            lock_q      <= 1'b0;
            lock_id_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (grant_s) begin
                fifo_q[wr_ptr_q] <= sel_s;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            prio_q      <= prio_d;
            lock_q      <= lock_d;
            lock_id_q   <= lock_id_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
module tb_obi_rr_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_req   [2];
    logic        m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_be    [2];
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_gnt, s_rvalid, s_we, s_err, perr;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    int tests = 0;
    int fails = 0;

    // Reference model state: queue of outstanding master IDs, oldest first.
    bit q[$];
    bit mprio, mlock, mlkid, mperr;

    always #5 clk = ~clk;

    obi_rr_arbiter #(.AW(32), .DW(32), .MAX_OUTST(MAXO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m_req[0]), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
        .m0_addr_i(m_addr[0]), .m0_we_i(m_we[0]), .m0_be_i(m_be[0]),
        .m0_wdata_i(m_wdata[0]), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m_req[1]), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
        .m1_addr_i(m_addr[1]), .m1_we_i(m_we[1]), .m1_be_i(m_be[1]),
        .m1_wdata_i(m_wdata[1]), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .s_req_o(s_req), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
        .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_rdata_i(s_rdata), .s_err_i(s_err), .proto_err_o(perr)
    );

    // Which master owns the slave this cycle, and whether a request goes out.
    function automatic void msel(output bit s, output bit sr);
        if (mlock)                      s = mlkid;
        else if (m_req[0] && m_req[1])  s = mprio;
        else                            s = m_req[1];
        sr = m_req[s] && (q.size() < MAXO);
    endfunction

    task automatic model_update();
        bit s, sr;
        if (rst) begin
            q.delete();
            mprio = 1'b0; mlock = 1'b0; mlkid = 1'b0; mperr = 1'b0;
        end else begin
            msel(s, sr);
            if (s_rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else              mperr = 1'b1;
            end
            if (sr && s_gnt) begin
                q.push_back(s);
                mprio = !s;
                mlock = 1'b0;
            end else if (sr) begin
                mlock = 1'b1;
                mlkid = s;
            end
        end
    endtask

    task automatic compare_cycle();
        bit s, sr, pop, hd;
        logic [140:0] e, a;
        msel(s, sr);
        pop = s_rvalid && (q.size() > 0);
        hd  = pop ? q[0] : 1'b0;
        e = {sr && s_gnt && !s, sr && s_gnt && s, pop && !hd, pop && hd,
             pop && !hd && s_err, pop && hd && s_err, sr, sr && m_we[s], mperr,
             sr ? m_be[s] : 4'h0, sr ? m_addr[s] : 32'h0, sr ? m_wdata[s] : 32'h0,
             (pop && !hd) ? s_rdata : 32'h0, (pop && hd) ? s_rdata : 32'h0};
        if (rst) e = '0;
        a = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, s_req, s_we, perr,
             s_be, s_addr, s_wdata, m0_rdata, m1_rdata};
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL cycle_model t=%0t act=%h exp=%h", $time, a, e);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            m_req[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = 32'h0;
            m_wdata[i] = 32'h0; m_be[i] = 4'h0;
        end
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0; s_err = 1'b0;
    endtask

    // Reset with busy inputs: every output must read 0 while reset is high.
    task automatic do_reset();
        rst = 1'b1;
        m_req[0] = 1'b1; m_req[1] = 1'b1; m_addr[0] = 32'h55; s_gnt = 1'b1; s_rvalid = 1'b1;
        #1;
        chk("rst_sreq", 32'(s_req), 32'd0);
        chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
        chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        chk("rst_addr", s_addr, 32'h0);
        idle();
        nxt(); nxt();
        rst = 1'b0;
    endtask

    initial begin
        bit g0, g1;
        rst = 1'b1;
        idle();
        fork
            forever begin
                @(posedge clk or posedge rst);
                model_update();
            end
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none
        nxt();
        do_reset();
        chk("rst_perr", 32'(perr), 32'd0);

        // Single master read.
        m_req[0] = 1'b1; m_addr[0] = 32'h100; m_be[0] = 4'hF; s_gnt = 1'b1;
        #2;
        chk("single_gnt0", 32'(m0_gnt), 32'd1);
        chk("single_gnt1", 32'(m1_gnt), 32'd0);
        chk("single_addr", s_addr, 32'h100);
        nxt();
        m_req[0] = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
        #2;
        chk("single_rv0", 32'(m0_rvalid), 32'd1);
        chk("single_rdata0", m0_rdata, 32'hDEADBEEF);
        chk("single_rv1", 32'(m1_rvalid), 32'd0);
        chk("single_rdata1", m1_rdata, 32'h0);
        nxt();
        idle();

        // Contention: grants alternate starting with m0.
        do_reset();
        m_req[0] = 1'b1; m_req[1] = 1'b1; m_addr[0] = 32'hA0; m_addr[1] = 32'hB0; s_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_rvalid = (i > 0);
            #2;
            chk("rr_gnt0", 32'(m0_gnt), 32'(i % 2 == 0));
            chk("rr_gnt1", 32'(m1_gnt), 32'(i % 2 == 1));
            if (i > 0) chk("rr_rv0", 32'(m0_rvalid), 32'((i - 1) % 2 == 0));
            nxt();
        end
        idle(); s_rvalid = 1'b1;
        nxt();
        idle();

        // Lock, backpressure, simultaneous push/pop, protocol error, reset.
        do_reset();
        m_req[1] = 1'b1; m_addr[1] = 32'h40;
        #2; chk("lock_addr_c0", s_addr, 32'h40); nxt();
        m_req[0] = 1'b1; m_addr[0] = 32'h80;
        #2; chk("lock_addr_c1", s_addr, 32'h40); chk("lock_gnt0_c1", 32'(m0_gnt), 32'd0); nxt();
        #2; chk("lock_addr_c2", s_addr, 32'h40); nxt();
        s_gnt = 1'b1;
        #2; chk("lock_gnt1", 32'(m1_gnt), 32'd1); chk("lock_gnt0", 32'(m0_gnt), 32'd0); nxt();
        m_req[1] = 1'b0;
        #2; chk("lock_next_gnt0", 32'(m0_gnt), 32'd1); chk("lock_next_addr", s_addr, 32'h80); nxt();
        m_addr[0] = 32'h84;
        #2; chk("bp_sreq_full", 32'(s_req), 32'd0); chk("bp_gnt0", 32'(m0_gnt), 32'd0); nxt();
        s_rvalid = 1'b1; s_rdata = 32'h11;
        #2; chk("bp_rv1", 32'(m1_rvalid), 32'd1); chk("bp_rdata1", m1_rdata, 32'h11);
        chk("bp_rv0", 32'(m0_rvalid), 32'd0); chk("bp_sreq_pop", 32'(s_req), 32'd0); nxt();
        s_rdata = 32'h22;
        #2; chk("bp_sreq_rise", 32'(s_req), 32'd1); chk("sim_gnt0", 32'(m0_gnt), 32'd1);
        chk("sim_rv0", 32'(m0_rvalid), 32'd1); chk("sim_rdata0", m0_rdata, 32'h22); nxt();
        m_req[0] = 1'b0; s_gnt = 1'b0; s_rdata = 32'h33;
        #2; chk("sim_queued_rv0", 32'(m0_rvalid), 32'd1); chk("sim_queued_rv1", 32'(m1_rvalid), 32'd0); nxt();
        #2; chk("perr_rv0", 32'(m0_rvalid), 32'd0); chk("perr_rv1", 32'(m1_rvalid), 32'd0); nxt();
        s_rvalid = 1'b0; m_req[0] = 1'b1; m_req[1] = 1'b1; s_gnt = 1'b1;
        #2; chk("perr_set", 32'(perr), 32'd1); nxt();
        rst = 1'b1; s_rvalid = 1'b1;
        #1;
        chk("midrst_sreq", 32'(s_req), 32'd0);
        chk("midrst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
        chk("midrst_rv", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        chk("midrst_perr", 32'(perr), 32'd0);
        idle(); nxt(); rst = 1'b0;
        s_rvalid = 1'b1; nxt(); s_rvalid = 1'b0;
        #2; chk("late_rsp_perr", 32'(perr), 32'd1);
        nxt();

        // Randomized traffic against the model.
        do_reset();
        g0 = 1'b0; g1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (rst) rst = 1'b0;
            for (int m = 0; m < 2; m++) begin
                if (!m_req[m] || (m == 0 ? g0 : g1)) begin
                    m_req[m]   = ($urandom_range(0, 9) < 6);
                    m_we[m]    = $urandom_range(0, 1);
                    m_addr[m]  = $urandom;
                    m_wdata[m] = $urandom;
                    m_be[m]    = 4'($urandom_range(0, 15));
                end
            end
            s_gnt   = $urandom_range(0, 2) != 0;
            s_rdata = $urandom;
            s_err   = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1; s_rvalid = 1'b0;
                m_req[0] = 1'b0; m_req[1] = 1'b0;
            end else begin
                s_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            end
            @(negedge clk);
            g0 = m0_gnt; g1 = m1_gnt;
            nxt();
        end
        rst = 1'b0;
        idle();
        nxt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
